uart_tx_serializer: RTL and testbench

Parametrised UART transmitter: accepts parallel words over a valid/ready handshake and drives a standard asynchronous serial frame (start, data LSB-first, optional parity, 1–2 stop bits) on a single line. It is the next generation of the team's transmit FSM. It replaces the fixed 8-bit, two-clock, self-check flow with a real bit-timed serializer on one clock, and adds a configurable frame format. It sits between the host-side data source and the pad driving the serial line.

---
 rtl/uart_tx_serializer.sv | 156 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
`default_nettype none
//==============================================================================
// Module  : uart_tx_serializer
// Brief   : Bit-timed UART transmitter: start, DATA_W bits LSB-first, optional
//           parity, 1-2 stop bits. Define UART_TX_HOLD_EN for a one-word
//           holding register that allows gap-free back-to-back frames.
// Rev     : 1.0  initial release
//==============================================================================
module uart_tx_serializer #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clka,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              tx_busy,
   output logic              tx_done,
   output logic [2:0]        tstate,
   output logic [3:0]        tcount
);

   localparam int              c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      c_BIT_LAST  = 4'(DATA_W - 1);
   localparam logic            c_ODD       = (PARITY_MODE == 2);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_PARITY = 3'd3;
   localparam logic [2:0] c_STOP   = 3'd4;

   logic [2:0]          r_state;
   logic [2:0]          w_next_state;
   logic [c_BAUD_W-1:0] r_baud;
   logic [3:0]          r_count;
   logic [DATA_W-1:0]   r_shift;
   logic                r_parity;
   logic                r_stop_idx;
   logic                w_xfer;
   logic                w_bit_end;
   logic                w_frame_end;
   logic                w_load;
   logic [DATA_W-1:0]   w_load_word;

   assign w_xfer      = tx_valid & tx_ready;
   assign w_bit_end   = (r_baud == c_BAUD_LAST);
   assign w_frame_end = (r_state == c_STOP) && w_bit_end && ((STOP_BITS == 1) || r_stop_idx);

`ifdef UART_TX_HOLD_EN
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;

   // A new frame starts from IDLE or straight out of the last stop cycle;
   // a parked word always has priority over the one arriving on the port.
   assign w_load      = ((r_state == c_IDLE) || w_frame_end) && (r_hold_full || w_xfer);
   assign w_load_word = r_hold_full ? r_hold : tx_data;

   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         r_hold      <= '0;
         r_hold_full <= 1'b0;
      end else if (w_load && r_hold_full) begin
         r_hold_full <= w_xfer;
         if (w_xfer)
            r_hold <= tx_data;
      end else if (w_xfer && !w_load) begin
         r_hold      <= tx_data;
         r_hold_full <= 1'b1;
      end
   end
`else
   assign w_load      = w_xfer;
   assign w_load_word = tx_data;
`endif

   always_ff @(posedge clka or negedge reset) begin
      if (!reset)
         r_state <= c_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:   if (w_load) w_next_state = c_START;
         c_START:  if (w_bit_end) w_next_state = c_DATA;
         c_DATA:   if (w_bit_end && (r_count == c_BIT_LAST))
                      w_next_state = (PARITY_MODE != 0) ? c_PARITY : c_STOP;
         c_PARITY: if (w_bit_end) w_next_state = c_STOP;
         c_STOP:   if (w_frame_end) w_next_state = w_load ? c_START : c_IDLE;
         default:  w_next_state = c_IDLE;
      endcase
   end

   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         r_baud     <= '0;
         r_count    <= '0;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_stop_idx <= 1'b0;
      end else begin
         // Every state entry happens on a bit boundary or out of IDLE, so this clears on entry.
         if ((r_state == c_IDLE) || w_bit_end)
            r_baud <= '0;
         else
            r_baud <= r_baud + 1'b1;

         if (w_load) begin
            r_shift  <= w_load_word;
            r_parity <= (^w_load_word) ^ c_ODD;
         end else if ((r_state == c_DATA) && w_bit_end) begin
            r_shift <= r_shift >> 1;
         end

         if (r_state != c_DATA)
            r_count <= '0;
         else if (w_bit_end)
            r_count <= (r_count == c_BIT_LAST) ? 4'd0 : r_count + 1'b1;

         if (r_state != c_STOP)
            r_stop_idx <= 1'b0;
         else if (w_bit_end)
            r_stop_idx <= ~r_stop_idx;
      end
   end

   always_comb begin
      tx_out  = 1'b1;
      tx_busy = (r_state != c_IDLE);
      tx_done = w_frame_end;
`ifdef UART_TX_HOLD_EN
      tx_ready = !r_hold_full;
`else
      tx_ready = (r_state == c_IDLE);
`endif
      case (r_state)
         c_START:  tx_out = 1'b0;
         c_DATA:   tx_out = r_shift[0];
         c_PARITY: tx_out = r_parity;
         default:  tx_out = 1'b1;
      endcase
   end

   assign tstate = r_state;
   assign tcount = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
//==============================================================================
// Module  : tb_uart_tx_serializer
// Brief   : Two serializer configurations driven with directed and random words;
//           accepted words are scoreboarded and frames decoded off the line.
// Rev     : 1.0  initial release
//==============================================================================
module tb_uart_tx_serializer;

   localparam int CPB    = 4;
   localparam int DW     = 8;
   localparam int PAR_A  = 1;
   localparam int STOP_A = 1;
   localparam int PAR_B  = 2;
   localparam int STOP_B = 2;

   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic reset;

   logic [7:0] din_a, din_b;
   logic       vld_a, vld_b;
   logic       rdy_a, out_a, busy_a, done_a;
   logic       rdy_b, out_b, busy_b, done_b;
   logic [2:0] st_a, st_b;
   logic [3:0] cnt_a, cnt_b;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   bit inf_a = 1'b0;
   bit inf_b = 1'b0;

   typedef struct {
      logic [7:0] w;
      int         t;
   } exp_t;

   typedef struct packed {
      logic       line;
      logic       done;
      logic       busy;
      logic       rdy;
      logic [2:0] st;
      logic [3:0] cnt;
   } obs_t;

   exp_t q_a[$];
   exp_t q_b[$];

   uart_tx_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_MODE(PAR_A), .STOP_BITS(STOP_A)) u_dut_a (
      .clka(clk), .reset(reset), .tx_data(din_a), .tx_valid(vld_a), .tx_ready(rdy_a),
      .tx_out(out_a), .tx_busy(busy_a), .tx_done(done_a), .tstate(st_a), .tcount(cnt_a));

   uart_tx_serializer #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .PARITY_MODE(PAR_B), .STOP_BITS(STOP_B)) u_dut_b (
      .clka(clk), .reset(reset), .tx_data(din_b), .tx_valid(vld_b), .tx_ready(rdy_b),
      .tx_out(out_b), .tx_busy(busy_b), .tx_done(done_b), .tstate(st_b), .tcount(cnt_b));

   initial begin
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference frame: bit b of the frame as the line must show it.
   function automatic logic model_bit(input logic [7:0] w, input int par, input int b);
      if (b == 0)                      return 1'b0;
      if (b <= DW)                     return w[b-1];
      if ((par != 0) && (b == DW + 1)) return (^w) ^ (par == 2);
      return 1'b1;
   endfunction

   function automatic int model_state(input int par, input int b);
      if (b == 0)                      return 1;
      if (b <= DW)                     return 2;
      if ((par != 0) && (b == DW + 1)) return 3;
      return 4;
   endfunction

   function automatic int frame_len(input int par, input int stops);
      return CPB * (1 + DW + ((par != 0) ? 1 : 0) + stops);
   endfunction

   function automatic obs_t obs(input int k);
      obs_t o;
      if (k == 0) o = {out_a, done_a, busy_a, rdy_a, st_a, cnt_a};
      else        o = {out_b, done_b, busy_b, rdy_b, st_b, cnt_b};
      return o;
   endfunction

   // Scoreboard push: every handshake queues the word and the cycle its frame may start.
   always @(posedge clk) begin
      if (reset && vld_a && rdy_a) q_a.push_back('{w: din_a, t: cyc + 1});
      if (reset && vld_b && rdy_b) q_b.push_back('{w: din_b, t: cyc + 1});
      cyc <= cyc + 1;
   end

   task automatic monitor(input int k);
      int    par   = (k == 0) ? PAR_A : PAR_B;
      int    stops = (k == 0) ? STOP_A : STOP_B;
      string nm    = (k == 0) ? "A" : "B";
      int    prev_end = 0;
      int    len, t0, b, qs;
      bit    aborted;
      obs_t  o;
      exp_t  e;
      len = frame_len(par, stops);
      forever begin
         @(negedge clk);
         o = obs(k);
         if (reset && !o.line) begin
            if (k == 0) inf_a = 1'b1; else inf_b = 1'b1;
            qs = (k == 0) ? q_a.size() : q_b.size();
            e.w = 8'h00;
            e.t = cyc;
            if (qs > 0) e = (k == 0) ? q_a.pop_front() : q_b.pop_front();
            check($sformatf("%s word pending at frame start", nm), (qs > 0), 1);
            t0 = cyc;
            check($sformatf("%s frame start cycle w=%02h", nm, e.w), t0, (e.t > prev_end) ? e.t : prev_end);
            aborted = 1'b0;
            for (int i = 0; i < len; i++) begin
               if (i > 0) begin
                  @(negedge clk);
                  o = obs(k);
               end
               if (!reset) begin
                  check($sformatf("%s line during reset", nm), o.line, 1);
                  check($sformatf("%s busy during reset", nm), o.busy, 0);
                  check($sformatf("%s done during reset", nm), o.done, 0);
                  aborted = 1'b1;
                  break;
               end
               b = i / CPB;
               check($sformatf("%s line w=%02h bit%0d cyc%0d", nm, e.w, b, i), o.line, model_bit(e.w, par, b));
               check($sformatf("%s done w=%02h cyc%0d", nm, e.w, i), o.done, (i == len - 1));
               check($sformatf("%s busy w=%02h cyc%0d", nm, e.w, i), o.busy, 1);
               check($sformatf("%s tstate w=%02h cyc%0d", nm, e.w, i), o.st, model_state(par, b));
               if ((b >= 1) && (b <= DW))
                  check($sformatf("%s tcount w=%02h cyc%0d", nm, e.w, i), o.cnt, b - 1);
`ifndef UART_TX_HOLD_EN
               check($sformatf("%s ready in frame cyc%0d", nm, i), o.rdy, 0);
`endif
            end
            prev_end = aborted ? 0 : t0 + len;
`ifndef UART_TX_HOLD_EN
            if (!aborted) begin
               @(negedge clk);
               o = obs(k);
               if (reset) begin
                  check($sformatf("%s gap line", nm), o.line, 1);
                  check($sformatf("%s gap busy", nm), o.busy, 0);
                  check($sformatf("%s gap ready", nm), o.rdy, 1);
                  check($sformatf("%s gap tstate", nm), o.st, 0);
               end
            end
`endif
            if (k == 0) inf_a = 1'b0; else inf_b = 1'b0;
         end
      end
   endtask

   task automatic send(input int k, input logic [7:0] w);
      int n = 0;
      if (k == 0) begin din_a = w; vld_a = 1'b1; end
      else        begin din_b = w; vld_b = 1'b1; end
      while ((((k == 0) ? rdy_a : rdy_b) !== 1'b1) && (n < 400)) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("%s accepted %02h within bound", (k == 0) ? "A" : "B", w), (n < 400), 1);
      if (n < 400) @(negedge clk);
      if (k == 0) vld_a = 1'b0; else vld_b = 1'b0;
   endtask

   task automatic wait_idle();
      int left = 0;
      for (int i = 0; i < 3000; i++) begin
         left = q_a.size() + q_b.size() + int'(inf_a) + int'(inf_b);
         if (left == 0) break;
         @(negedge clk);
      end
      check("scoreboard drained", left, 0);
   endtask

   initial begin
      reset = 1'b1;
      vld_a = 1'b0;  vld_b = 1'b0;
      din_a = 8'h00; din_b = 8'h00;
      #1 reset = 1'b0;
      #2;
      check("A reset tx_out", out_a, 1);
      check("A reset tx_ready", rdy_a, 1);
      check("A reset tx_busy", busy_a, 0);
      check("A reset tx_done", done_a, 0);
      check("A reset tstate", st_a, 0);
      check("A reset tcount", cnt_a, 0);
      check("B reset tx_out", out_b, 1);
      check("B reset tx_ready", rdy_b, 1);
      check("B reset tx_busy", busy_b, 0);
      check("B reset tstate", st_b, 0);
      #2 reset = 1'b1;
      clk_en = 1'b1;
      fork
         monitor(0);
         monitor(1);
      join_none
      @(negedge clk);

      fork
         send(0, 8'hA5);
         send(1, 8'h07);
      join
      wait_idle();

      // Second word is presented while the first frame is still on the line.
      send(0, 8'hC3);
      send(0, 8'h3C);
      wait_idle();

      fork
         repeat (12) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(0, 8'($urandom));
         end
         repeat (12) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send(1, 8'($urandom));
         end
      join
      wait_idle();

      send(0, 8'h96);
      repeat (17) @(negedge clk);
      check("A tcount before reset pulse", cnt_a, 3);
      #2 reset = 1'b0;
      #1;
      check("A line after async reset", out_a, 1);
      check("A done after async reset", done_a, 0);
      check("A busy after async reset", busy_a, 0);
      check("A tstate after async reset", st_a, 0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      send(0, 8'($urandom));
      wait_idle();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
